int_ctrl: RTL and testbench

- Interrupt controller that drives the pipeline's interrupt interface: int_set_pl_pause, int_flag and int_pc.
- Arbitrates level-sensitive IRQ lines and freezes the pipeline while outstanding memory traffic settles.
- Redirects fetch to a per-IRQ vector and saves the resume PC in EPC.
- On mret, redirects fetch back to EPC through the same int_flag/int_pc path.

---
 rtl/int_ctrl_pkg.sv | 32 +++
 rtl/int_ctrl_prio_enc.sv | 24 ++
 rtl/int_ctrl.sv | 153 +++++++++++++++
 tb/tb_int_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller and its pipeline hooks.
//   - PL status codes used by the pipeline control logic
//   - int_ctrl FSM state encodings
//   - default vector base and the vector-address helper
package int_ctrl_pkg;

  // Pipeline status codes
  typedef enum logic [1:0] {
    PL_RUN   = 2'd0,
    PL_STALL = 2'd1,
    PL_PAUSE = 2'd2,
    PL_FLUSH = 2'd3
  } pl_status_e;

  // Interrupt controller FSM states
  typedef enum logic [2:0] {
    INT_IDLE     = 3'd0,
    INT_DRAIN    = 3'd1,
    INT_REDIRECT = 3'd2,
    INT_SERVICE  = 3'd3,
    INT_RETURN   = 3'd4
  } int_state_e;

  localparam logic [31:0] INT_VEC_BASE = 32'h0000_0100;

  // Handler address for IRQ idx: one word per vector, 32-bit wrap.
  function automatic logic [31:0] int_vec_pc(input logic [31:0] base,
                                             input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
// Ports:
//   req   in  NUM_IRQ        request vector
//   valid out 1              any request set
//   id    out $clog2(NUM_IRQ) index of lowest set bit (0 when none)
module irq_prio_enc #(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan high to low so the lowest set index is written last.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller driving the pipeline interrupt interface.
// Arbitrates level IRQs, pauses the pipeline while memory traffic drains,
// redirects fetch to the IRQ vector, and redirects back to EPC on mret.
// Ports:
//   clk, clrn                 clock, async active-low reset
//   irq, irq_mask, global_en  request lines, per-line enable, global enable
//   branch                    branch redirect issued this cycle
//   mem_busy                  data-memory transaction outstanding
//   resume_pc                 PC of oldest instruction not yet written back
//   mret                      return-from-interrupt pulse
//   int_set_pl_pause          freeze the pipeline
//   int_flag / int_pc         one-cycle redirect pulse and target
//   epc, in_service, irq_ack, irq_id   service status
// All outputs are registered; they are computed from the next state.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter  int          NUM_IRQ      = 8,
  parameter  logic [31:0] VEC_BASE     = INT_VEC_BASE,
  parameter  int          DRAIN_CYCLES = 3,
  localparam int          ID_W         = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               global_en,
  input  logic               branch,
  input  logic               mem_busy,
  input  logic [31:0]        resume_pc,
  input  logic               mret,
  output logic               int_set_pl_pause,
  output logic               int_flag,
  output logic [31:0]        int_pc,
  output logic [31:0]        epc,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [ID_W-1:0]    irq_id
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  int_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        epc_q, epc_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               pause_q, pause_d;
  logic               flag_q, flag_d;
  logic [31:0]        pc_q, pc_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               svc_q, svc_d;

  logic [NUM_IRQ-1:0] req;
  logic               req_vld;
  logic [ID_W-1:0]    req_id;

  // No nesting: requests are invisible while a handler runs.
  assign req = irq & irq_mask & {NUM_IRQ{global_en & ~svc_q}};

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (req),
    .valid (req_vld),
    .id    (req_id)
  );

  // Next-state and latched service context
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    id_d    = id_q;
    case (state_q)
      INT_IDLE: begin
        // A same-cycle branch defers entry so resume_pc holds the target.
        if (req_vld && !branch) begin
          state_d = INT_DRAIN;
          id_d    = req_id;
          epc_d   = resume_pc;
          cnt_d   = '0;
        end
      end
      INT_DRAIN: begin
        if (cnt_q >= DRAIN_LAST && !mem_busy) begin
          state_d = INT_REDIRECT;
        end else if (cnt_q != 4'hF) begin
          // Saturate so a long mem_busy stall cannot wrap below the limit.
          cnt_d = cnt_q + 4'd1;
        end
      end
      INT_REDIRECT: state_d = INT_SERVICE;
      INT_SERVICE:  if (mret) state_d = INT_RETURN;
      INT_RETURN:   state_d = INT_IDLE;
      default:      state_d = INT_IDLE;
    endcase
  end

  // Moore outputs, decoded from the next state and registered.
  always_comb begin
    pause_d = 1'b0;
    flag_d  = 1'b0;
    pc_d    = '0;
    ack_d   = '0;
    svc_d   = 1'b0;
    case (state_d)
      INT_DRAIN: pause_d = 1'b1;
      INT_REDIRECT: begin
        flag_d = 1'b1;
        pc_d   = int_vec_pc(VEC_BASE, 32'(id_d));
        ack_d  = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_d;
      end
      INT_SERVICE: svc_d = 1'b1;
      INT_RETURN: begin
        flag_d = 1'b1;
        pc_d   = epc_d;
        svc_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= INT_IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      id_q    <= '0;
      pause_q <= 1'b0;
      flag_q  <= 1'b0;
      pc_q    <= '0;
      ack_q   <= '0;
      svc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      id_q    <= id_d;
      pause_q <= pause_d;
      flag_q  <= flag_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      svc_q   <= svc_d;
    end
  end

  assign int_set_pl_pause = pause_q;
  assign int_flag         = flag_q;
  assign int_pc           = pc_q;
  assign epc              = epc_q;
  assign in_service       = svc_q;
  assign irq_ack          = ack_q;
  assign irq_id           = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with default parameters.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  irq, irq_mask;
  logic        global_en, branch, mem_busy, mret;
  logic [31:0] resume_pc;
  logic        int_set_pl_pause, int_flag, in_service;
  logic [31:0] int_pc, epc;
  logic [7:0]  irq_ack;
  logic [2:0]  irq_id;

  int errors = 0;
  int checks = 0;

  int_ctrl dut (
    .clk(clk), .clrn(clrn), .irq(irq), .irq_mask(irq_mask),
    .global_en(global_en), .branch(branch), .mem_busy(mem_busy),
    .resume_pc(resume_pc), .mret(mret),
    .int_set_pl_pause(int_set_pl_pause), .int_flag(int_flag),
    .int_pc(int_pc), .epc(epc), .in_service(in_service),
    .irq_ack(irq_ack), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic [7:0]  mask;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [7:0]  exp_ack;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts pause cycles until it drops; lands in the cycle after.
  task automatic run_to_flag(output int n);
    n = 0;
    while (int_set_pl_pause && n < 50) begin
      n++;
      step();
    end
  endtask

  // From REDIRECT: SERVICE, mret -> RETURN to exp_epc, then IDLE.
  task automatic finish_service(input string nm, input logic [31:0] exp_epc);
    step();
    chk({nm, " svc"}, {31'd0, in_service}, 1);
    chk({nm, " svc flag"}, {31'd0, int_flag}, 0);
    chk({nm, " svc pc"}, int_pc, 0);
    chk({nm, " svc ack"}, {24'd0, irq_ack}, 0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk({nm, " ret flag"}, {31'd0, int_flag}, 1);
    chk({nm, " ret pc"}, int_pc, exp_epc);
    chk({nm, " ret svc"}, {31'd0, in_service}, 1);
    step();
    chk({nm, " idle svc"}, {31'd0, in_service}, 0);
    chk({nm, " idle flag"}, {31'd0, int_flag}, 0);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{8'b0010_0100, 8'hFF, 32'h40,   32'h108, 8'h04, 3'd2};
    vecs[1] = '{8'h80,        8'hFF, 32'h1234, 32'h11C, 8'h80, 3'd7};
    vecs[2] = '{8'hF0,        8'hC0, 32'h200,  32'h118, 8'h40, 3'd6};
    vecs[3] = '{8'h03,        8'hFF, 32'h3C,   32'h100, 8'h01, 3'd0};

    clrn = 1'b0; irq = '0; irq_mask = 8'hFF; global_en = 1'b1;
    branch = 1'b0; mem_busy = 1'b0; mret = 1'b0; resume_pc = '0;
    #12;
    chk("rst pause", {31'd0, int_set_pl_pause}, 0);
    chk("rst flag", {31'd0, int_flag}, 0);
    chk("rst pc", int_pc, 0);
    chk("rst epc", epc, 0);
    chk("rst svc", {31'd0, in_service}, 0);
    chk("rst ack", {24'd0, irq_ack}, 0);
    chk("rst id", {29'd0, irq_id}, 0);
    clrn = 1'b1;
    step();

    // Table-driven full sequences
    foreach (vecs[i]) begin
      irq = vecs[i].irq; irq_mask = vecs[i].mask; resume_pc = vecs[i].rpc;
      step();
      run_to_flag(n);
      chk($sformatf("v%0d pause len", i), n, 3);
      chk($sformatf("v%0d flag", i), {31'd0, int_flag}, 1);
      chk($sformatf("v%0d pause@flag", i), {31'd0, int_set_pl_pause}, 0);
      chk($sformatf("v%0d pc", i), int_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d ack", i), {24'd0, irq_ack}, {24'd0, vecs[i].exp_ack});
      chk($sformatf("v%0d epc", i), epc, vecs[i].rpc);
      chk($sformatf("v%0d id", i), {29'd0, irq_id}, {29'd0, vecs[i].exp_id});
      irq = '0;
      finish_service($sformatf("v%0d", i), vecs[i].rpc);
    end
    irq_mask = 8'hFF;

    // Masked line, then global disable: nothing happens
    irq = 8'h01; irq_mask = 8'hFE;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (int_set_pl_pause || int_flag) seen++;
    end
    chk("masked quiet", seen, 0);
    irq_mask = 8'hFF; global_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (int_set_pl_pause || int_flag) seen++;
    end
    chk("gdis quiet", seen, 0);
    irq = '0; global_en = 1'b1;

    // mret outside SERVICE ignored
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("stray mret", {31'd0, int_flag}, 0);
    step();

    // mem_busy stretches DRAIN: busy for the first 5 pause cycles
    irq = 8'h01; resume_pc = 32'h40; mem_busy = 1'b1;
    step();
    n = 0;
    while (int_set_pl_pause && n < 50) begin
      n++;
      if (n >= 6) mem_busy = 1'b0;
      step();
    end
    chk("busy pause len", n, 6);
    chk("busy flag", {31'd0, int_flag}, 1);
    chk("busy pc", int_pc, 32'h100);
    irq = '0; mem_busy = 1'b0;
    finish_service("busy", 32'h40);

    // No nesting; pending irq[1] taken after return
    irq = 8'h01; resume_pc = 32'h40;
    step();
    run_to_flag(n);
    chk("nest pc0", int_pc, 32'h100);
    irq = 8'h02;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (int_set_pl_pause || int_flag || !in_service) seen++;
    end
    chk("nest ignored", seen, 0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("nest ret flag", {31'd0, int_flag}, 1);
    chk("nest ret pc", int_pc, 32'h40);
    resume_pc = 32'h50;
    step();
    chk("nest idle", {31'd0, in_service | int_set_pl_pause}, 0);
    step();
    run_to_flag(n);
    chk("nest2 pause len", n, 3);
    chk("nest2 pc", int_pc, 32'h104);
    chk("nest2 epc", epc, 32'h50);
    chk("nest2 id", {29'd0, irq_id}, 1);
    irq = '0;
    finish_service("nest2", 32'h50);

    // Branch in the request cycle defers entry by one cycle
    irq = 8'h01; branch = 1'b1; resume_pc = 32'h20;
    step();
    chk("br defer", {31'd0, int_set_pl_pause}, 0);
    branch = 1'b0; resume_pc = 32'h80;
    step();
    chk("br entry", {31'd0, int_set_pl_pause}, 1);
    run_to_flag(n);
    chk("br pause len", n, 3);
    chk("br epc", epc, 32'h80);
    irq = '0;
    finish_service("br", 32'h80);

    // Async reset mid-DRAIN, then restart from the held irq
    irq = 8'h04; resume_pc = 32'h44;
    step();
    step();
    chk("pre-rst pause", {31'd0, int_set_pl_pause}, 1);
    #2 clrn = 1'b0;
    #1;
    chk("arst pause", {31'd0, int_set_pl_pause}, 0);
    chk("arst epc", epc, 0);
    chk("arst id", {29'd0, irq_id}, 0);
    chk("arst flag", {31'd0, int_flag | in_service}, 0);
    @(posedge clk);
    #2 clrn = 1'b1;
    step();
    chk("rst restart", {31'd0, int_set_pl_pause}, 1);
    run_to_flag(n);
    chk("rst pause len", n, 3);
    chk("rst pc", int_pc, 32'h108);
    chk("rst ack2", {24'd0, irq_ack}, 32'h04);
    irq = '0;
    finish_service("rst", 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
